// File: rtl/key_cond_pkg.sv
// Shared definitions for the key conditioner: channel FSM encoding and
// the counter-width helper used to size prescaler and debounce/hold counters.
package key_cond_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PDEB = 3'd1,
    ST_HELD = 3'd2,
    ST_LONG = 3'd3,
    ST_RDEB = 3'd4
  } key_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_cond_ch.sv
// One key channel: two-flop synchroniser, polarity normalisation, and the
// debounce / long-press / auto-repeat state machine with registered pulses.
module key_cond_ch
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 800,
  parameter int REPEAT_TICKS   = 150,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DW   = cnt_width(DEBOUNCE_TICKS);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = cnt_width(HMAX);
  localparam logic          IDLE_RAW = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] LNG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_TICKS - 1);

  logic [1:0]    sync_q;
  logic          act_s;
  key_state_e    state_q, state_d, ret_q, ret_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d, release_q, release_d;
  logic          long_q, long_d, repeat_q, repeat_d;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {IDLE_RAW, IDLE_RAW};
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  assign act_s = sync_q[1] ^ IDLE_RAW;

  // Next-state logic: level changes on act act every clk, counters only on tick.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dcnt_d = '0;
        if (act_s) state_d = ST_PDEB;
        else       state_d = ST_IDLE;
      end
      ST_PDEB: begin
        if (!act_s) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end else if (tick) begin
          if (dcnt_q >= DEB_LAST) begin
            state_d = ST_HELD;
            dcnt_d  = '0;
            hcnt_d  = '0;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q;
        end
      end
      ST_HELD: begin
        if (!act_s) begin
          state_d = ST_RDEB;
          ret_d   = ST_HELD;
          dcnt_d  = '0;
        end else if (tick) begin
          if (hcnt_q >= LNG_LAST) begin
            state_d = ST_LONG;
            hcnt_d  = '0;
            long_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q;
        end
      end
      ST_LONG: begin
        if (!act_s) begin
          state_d = ST_RDEB;
          ret_d   = ST_LONG;
          dcnt_d  = '0;
        end else if (tick) begin
          if (hcnt_q >= REP_LAST) begin
            hcnt_d   = '0;
            repeat_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q;
        end
      end
      ST_RDEB: begin
        // hcnt stays frozen so a bounced release resumes the hold timing.
        if (act_s) begin
          state_d = ret_q;
          dcnt_d  = '0;
        end else if (tick) begin
          if (dcnt_q >= DEB_LAST) begin
            state_d   = ST_IDLE;
            dcnt_d    = '0;
            hcnt_d    = '0;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
        hcnt_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_HELD;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: shared millisecond prescaler feeding NUM_KEYS
// independent debounce / long-press / repeat channels.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS       = 2,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 800,
  parameter int REPEAT_TICKS   = 150,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                tick
);

  localparam int            PW       = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_q, tick_d;

  // Prescaler wrap; tick is registered so it lines up with count == TICK_DIV-1.
  always_comb begin
    if (pcnt_q >= PRE_LAST) pcnt_d = '0;
    else                    pcnt_d = pcnt_q + 1'b1;
    tick_d = (pcnt_d == PRE_LAST);
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_cond_ch #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick_q),
      .key_raw     (key_raw[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench: an active-low and an active-high key_conditioner; the
// stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_key_conditioner;

  typedef struct packed {
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] rep;
    logic [1:0] lvl;
    logic [7:0] gap;   // ticks since previous event, 8'hFF = don't care
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] raw     [2];
  logic [1:0] k_level [2];
  logic [1:0] k_press [2];
  logic [1:0] k_rel   [2];
  logic [1:0] k_long  [2];
  logic [1:0] k_rep   [2];
  logic       tick_w  [2];

  ev_t exp_q [2][$];
  int  gap [2];
  int  vectors     = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS(2), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .LONG_TICKS(10),
    .REPEAT_TICKS(4), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(raw[0]), .key_level(k_level[0]),
    .key_press(k_press[0]), .key_release(k_rel[0]), .key_long(k_long[0]),
    .key_repeat(k_rep[0]), .tick(tick_w[0])
  );

  key_conditioner #(
    .NUM_KEYS(2), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .LONG_TICKS(10),
    .REPEAT_TICKS(4), .KEY_ACTIVE_LOW(0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .key_raw(raw[1]), .key_level(k_level[1]),
    .key_press(k_press[1]), .key_release(k_rel[1]), .key_long(k_long[1]),
    .key_repeat(k_rep[1]), .tick(tick_w[1])
  );

  function automatic ev_t mk(input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] l, input logic [1:0] rp,
                             input logic [1:0] lv, input logic [7:0] g);
    ev_t e;
    e.press = p; e.rel = r; e.lng = l; e.rep = rp; e.lvl = lv; e.gap = g;
    return e;
  endfunction

  // Monitor: any pulse on a DUT pops one expected event for that DUT.
  initial begin
    ev_t obs;
    ev_t e;
    gap[0] = 0;
    gap[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          gap[d] = 0;
        end else if (tick_w[d]) begin
          gap[d] = gap[d] + 1;
        end else if ((k_press[d] | k_rel[d] | k_long[d] | k_rep[d]) != 2'b00) begin
          obs = mk(k_press[d], k_rel[d], k_long[d], k_rep[d], k_level[d], 8'(gap[d]));
          gap[d] = 0;
          vectors++;
          if (exp_q[d].size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event dut%0d @%0t: got p=%b r=%b l=%b rp=%b lvl=%b, required no event",
                     d, $time, obs.press, obs.rel, obs.lng, obs.rep, obs.lvl);
          end else begin
            e = exp_q[d].pop_front();
            if (obs[17:8] != e[17:8] || (e.gap != 8'hFF && obs.gap != e.gap)) begin
              miscompares++;
              $display("FAIL event dut%0d @%0t: got p=%b r=%b l=%b rp=%b lvl=%b gap=%0d, required p=%b r=%b l=%b rp=%b lvl=%b gap=%0d",
                       d, $time, obs.press, obs.rel, obs.lng, obs.rep, obs.lvl, obs.gap,
                       e.press, e.rel, e.lng, e.rep, e.lvl, e.gap);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic wait_tick(input int d, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!tick_w[d] && t < 100);
      if (!tick_w[d]) begin
        vectors++;
        miscompares++;
        $display("FAIL tick_timeout dut%0d: got no tick in %0d clk, required one", d, t);
      end
    end
  endtask

  // kind: 0 press, 1 release, 2 long, 3 repeat
  task automatic wait_evt(input int d, input int kind, output int cyc);
    logic [1:0] s;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      case (kind)
        0:       s = k_press[d];
        1:       s = k_rel[d];
        2:       s = k_long[d];
        default: s = k_rep[d];
      endcase
    end while (s == 2'b00 && cyc < 3000);
    if (s == 2'b00) begin
      vectors++;
      miscompares++;
      $display("FAIL event_timeout dut%0d kind%0d: got no pulse in %0d clk, required one", d, kind, cyc);
    end
  endtask

  task automatic drained(input int d, input logic [1:0] lvl);
    repeat (40) @(negedge clk);
    check($sformatf("queue_drained_dut%0d", d), 32'(exp_q[d].size()), 32'd0);
    check($sformatf("level_dut%0d", d), 32'(k_level[d]), 32'(lvl));
  endtask

  // Hold an accepted press 23 ticks, then release cleanly.
  task automatic hold_release(input int d, input logic act_lvl);
    int c;
    exp_q[d].push_back(mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 8'd10));
    for (int i = 0; i < 3; i++) exp_q[d].push_back(mk(2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 8'd4));
    exp_q[d].push_back(mk(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'd4));
    wait_tick(d, 23);
    raw[d][0] = ~act_lvl;
    wait_evt(d, 1, c);
    drained(d, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n  = 1'b1;
    raw[0] = 2'b11;
    raw[1] = 2'b00;
    #2 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_level", 32'({k_level[0], k_level[1]}), 32'd0);
    check("reset_pulses", 32'({k_press[0], k_rel[0], k_long[0], k_rep[0]}), 32'd0);
    check("reset_tick", 32'({tick_w[0], tick_w[1]}), 32'd0);
    rst_n = 1'b1;

    // Idle: tick period and quiet outputs.
    wait_tick(0, 1);
    for (int i = 0; i < 3; i++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!tick_w[0] && c < 100);
      check("tick_period", 32'(c), 32'd4);
      check("tick_shared", 32'(tick_w[1]), 32'd1);
    end
    repeat (1000) @(negedge clk);
    check("idle_level", 32'({k_level[0], k_level[1]}), 32'd0);

    // Bounce rejection, then a clean press.
    for (int i = 0; i < 10; i++) begin
      raw[0][0] = 1'b0;
      repeat (5) @(negedge clk);
      raw[0][0] = 1'b1;
      repeat (3) @(negedge clk);
    end
    drained(0, 2'b00);
    exp_q[0].push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 8'hFF));
    raw[0][0] = 1'b0;
    wait_evt(0, 0, c);
    vectors++;
    if (c < 11 || c > 15) begin
      miscompares++;
      $display("FAIL press_latency: got %0d clk, required 11..15", c);
    end
    check("press_level", 32'(k_level[0]), 32'd1);

    // Long press and repeat.
    hold_release(0, 1'b0);

    // Release bounce in HELD: hcnt frozen for the two ticks spent in RDEB.
    exp_q[0].push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 8'hFF));
    raw[0][0] = 1'b0;
    wait_evt(0, 0, c);
    exp_q[0].push_back(mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 8'd12));
    exp_q[0].push_back(mk(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'd4));
    wait_tick(0, 3);
    raw[0][0] = 1'b1;
    repeat (6) @(negedge clk);
    raw[0][0] = 1'b0;
    wait_evt(0, 2, c);
    check("bounce_level_kept", 32'(k_level[0]), 32'd1);
    wait_tick(0, 1);
    raw[0][0] = 1'b1;
    wait_evt(0, 1, c);
    drained(0, 2'b00);

    // Both keys together, then reset mid-hold.
    exp_q[0].push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8'hFF));
    raw[0] = 2'b00;
    wait_evt(0, 0, c);
    wait_tick(0, 2);
    rst_n = 1'b0;
    #1;
    check("async_reset_level", 32'(k_level[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("queue_before_rerelease", 32'(exp_q[0].size()), 32'd0);
    exp_q[0].push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8'hFF));
    rst_n = 1'b1;
    wait_evt(0, 0, c);
    exp_q[0].push_back(mk(2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 8'hFF));
    raw[0] = 2'b11;
    wait_evt(0, 1, c);
    drained(0, 2'b00);

    // Active-high polarity repeats the long-press sequence.
    exp_q[1].push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 8'hFF));
    raw[1][0] = 1'b1;
    wait_evt(1, 0, c);
    hold_release(1, 1'b1);
    drained(0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
